// File: rtl/axi_lite_regfile_slave.sv
// AXI-Lite register-file responder on valid/ack endpoints: independent write (AW/W/B) and read (AR/R) FSMs.
// Optional: define AXIL_REGFILE_ID_REG_EN to make register 0 a read-only ID register returning ID_VALUE.
module axi_lite_regfile_slave #(
  parameter int          NUM_REGS = 8,
  parameter logic [31:0] ID_VALUE = 32'hA11E_0001
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     _ep_aw_req_valid,
  output logic                     _ep_aw_req_ack,
  input  logic [34:0]              _ep_aw_req_0,
  input  logic                     _ep_w_req_valid,
  output logic                     _ep_w_req_ack,
  input  logic [35:0]              _ep_w_req_0,
  output logic                     _ep_b_resp_valid,
  input  logic                     _ep_b_resp_ack,
  output logic [1:0]               _ep_b_resp_0,
  input  logic                     _ep_ar_req_valid,
  output logic                     _ep_ar_req_ack,
  input  logic [34:0]              _ep_ar_req_0,
  output logic                     _ep_r_resp_valid,
  input  logic                     _ep_r_resp_ack,
  output logic [33:0]              _ep_r_resp_0,
  output logic [NUM_REGS*32-1:0]   regs_o,
  output logic [NUM_REGS-1:0]      wr_pulse_o
);
  localparam int IDXW = $clog2(NUM_REGS);
`ifdef AXIL_REGFILE_ID_REG_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {W_COLLECT, W_COMMIT, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}              r_state_e;

  logic [31:0] regs_q [NUM_REGS];

  w_state_e    w_state;
  logic        aw_have, w_have;
  logic [31:0] aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;
  logic [1:0]  b_resp_q;

  r_state_e    r_state;
  logic [31:0] r_data_q;
  logic [1:0]  r_resp_q;

  logic unused_prot;
  assign unused_prot = ^{_ep_aw_req_0[2:0], _ep_ar_req_0[2:0]};

  // Acks/valids come from registered state only; rst_i gating keeps them low in reset cycles.
  assign _ep_aw_req_ack  = !rst_i && (w_state == W_COLLECT) && !aw_have;
  assign _ep_w_req_ack   = !rst_i && (w_state == W_COLLECT) && !w_have;
  assign _ep_b_resp_valid = !rst_i && (w_state == W_RESP);
  assign _ep_b_resp_0    = b_resp_q;
  assign _ep_ar_req_ack  = !rst_i && (r_state == R_IDLE);
  assign _ep_r_resp_valid = !rst_i && (r_state == R_DATA);
  assign _ep_r_resp_0    = {r_data_q, r_resp_q};

  logic aw_xfer, w_xfer, b_xfer, ar_xfer, r_xfer;
  assign aw_xfer = _ep_aw_req_valid && _ep_aw_req_ack;
  assign w_xfer  = _ep_w_req_valid  && _ep_w_req_ack;
  assign b_xfer  = _ep_b_resp_valid && _ep_b_resp_ack;
  assign ar_xfer = _ep_ar_req_valid && _ep_ar_req_ack;
  assign r_xfer  = _ep_r_resp_valid && _ep_r_resp_ack;

  logic [IDXW-1:0] w_idx, ar_idx;
  logic [31:0]     ar_addr;
  logic            w_in_range, w_ok, ar_in_range;
  assign w_idx       = aw_addr_q[IDXW+1:2];
  assign w_in_range  = (aw_addr_q >> (IDXW + 2)) == 32'd0;
  assign w_ok        = w_in_range && !(ID_EN && (w_idx == '0));
  assign ar_addr     = _ep_ar_req_0[34:3];
  assign ar_idx      = ar_addr[IDXW+1:2];
  assign ar_in_range = (ar_addr >> (IDXW + 2)) == 32'd0;

  logic commit_ok;
  assign commit_ok = !rst_i && (w_state == W_COMMIT) && w_ok;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    assign wr_pulse_o[k]      = commit_ok && (w_idx == IDXW'(k));
    assign regs_o[32*k +: 32] = regs_q[k];
    if (ID_EN && k == 0) begin : g_id
      assign regs_q[k] = ID_VALUE;
    end else begin : g_rw
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          regs_q[k] <= '0;
        end else if (wr_pulse_o[k]) begin
          for (int b = 0; b < 4; b++)
            if (w_strb_q[b]) regs_q[k][8*b +: 8] <= w_data_q[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      w_state   <= W_COLLECT;
      aw_have   <= 1'b0;
      w_have    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      b_resp_q  <= OKAY;
    end else begin
      case (w_state)
        W_COLLECT: begin
          if (aw_xfer) begin
            aw_addr_q <= _ep_aw_req_0[34:3];
            aw_have   <= 1'b1;
          end
          if (w_xfer) begin
            w_data_q <= _ep_w_req_0[35:4];
            w_strb_q <= _ep_w_req_0[3:0];
            w_have   <= 1'b1;
          end
          if ((aw_have || aw_xfer) && (w_have || w_xfer)) w_state <= W_COMMIT;
        end
        W_COMMIT: begin
          b_resp_q <= w_ok ? OKAY : SLVERR;
          w_state  <= W_RESP;
        end
        W_RESP: begin
          if (b_xfer) begin
            w_state <= W_COLLECT;
            aw_have <= 1'b0;
            w_have  <= 1'b0;
          end
        end
        default: w_state <= W_COLLECT;
      endcase
    end
  end

  // Read samples the array before any same-cycle commit lands, so collisions see old data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= R_IDLE;
      r_data_q <= '0;
      r_resp_q <= OKAY;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_xfer) begin
            r_data_q <= ar_in_range ? regs_q[ar_idx] : 32'd0;
            r_resp_q <= ar_in_range ? OKAY : SLVERR;
            r_state  <= R_DATA;
          end
        end
        R_DATA: if (r_xfer) r_state <= R_IDLE;
        default: r_state <= R_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Self-checking bench for axi_lite_regfile_slave: vector table, hand-written corner sequences, random ops vs. model.
module tb_axi_lite_regfile_slave;
  localparam int NR = 8;
  localparam logic [31:0] ID_VAL = 32'hA11E_0001;
`ifdef AXIL_REGFILE_ID_REG_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif

  logic clk_i = 1'b0, rst_i = 1'b1;
  always #5 clk_i = ~clk_i;

  logic aw_valid = 0, aw_ack, w_valid = 0, w_ack, b_valid, b_ack = 0;
  logic ar_valid = 0, ar_ack, r_valid, r_ack = 0;
  logic [34:0] aw_data = '0, ar_data = '0;
  logic [35:0] w_data = '0;
  logic [1:0]  b_resp;
  logic [33:0] r_resp;
  logic [NR*32-1:0] regs_o;
  logic [NR-1:0]    wr_pulse;

  axi_lite_regfile_slave #(.NUM_REGS(NR), .ID_VALUE(ID_VAL)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    ._ep_aw_req_valid(aw_valid), ._ep_aw_req_ack(aw_ack), ._ep_aw_req_0(aw_data),
    ._ep_w_req_valid(w_valid), ._ep_w_req_ack(w_ack), ._ep_w_req_0(w_data),
    ._ep_b_resp_valid(b_valid), ._ep_b_resp_ack(b_ack), ._ep_b_resp_0(b_resp),
    ._ep_ar_req_valid(ar_valid), ._ep_ar_req_ack(ar_ack), ._ep_ar_req_0(ar_data),
    ._ep_r_resp_valid(r_valid), ._ep_r_resp_ack(r_ack), ._ep_r_resp_0(r_resp),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse)
  );

  int errors = 0, checks = 0;
  logic [31:0] model [NR];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference model: plain address arithmetic over a word array.
  function automatic logic [31:0] m_view(input int k);
    return (ID_EN && k == 0) ? ID_VAL : model[k];
  endfunction

  task automatic m_write(input logic [31:0] a, d, input logic [3:0] s,
                         output logic [1:0] resp, output logic [NR-1:0] pulse);
    int k;
    pulse = '0;
    if (a >= NR*4 || (ID_EN && a < 4)) begin
      resp = 2'b10;
    end else begin
      k = int'(a / 4);
      for (int b = 0; b < 4; b++)
        if (s[b]) model[k] = (model[k] & ~(32'hFF << (8*b))) | (d & (32'hFF << (8*b)));
      pulse = NR'(1) << k;
      resp = 2'b00;
    end
  endtask

  task automatic m_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    if (a >= NR*4) begin d = 0; resp = 2'b10; end
    else begin d = m_view(int'(a / 4)); resp = 2'b00; end
  endtask

  task automatic chk_regs(input string tag);
    for (int k = 0; k < NR; k++)
      chk($sformatf("%s regs_o[%0d]", tag, k), 64'(regs_o[32*k +: 32]), 64'(m_view(k)));
  endtask

  task automatic tick();
    @(posedge clk_i); #1;
  endtask

  // Called 1ns after an edge; returns 1ns after the edge that completes B.
  task automatic do_write(input logic [31:0] a, d, input logic [3:0] s, input int awd, wd, bstall,
                          output logic [1:0] resp, output logic [NR-1:0] pulse);
    bit awdn = 0, wdn = 0, ax, wx;
    int cyc = 0;
    logic [1:0] r0;
    while (!(awdn && wdn) && cyc < 50) begin
      aw_valid = !awdn && cyc >= awd; aw_data = {a, 3'($urandom)};
      w_valid  = !wdn && cyc >= wd;   w_data  = {d, s};
      ax = aw_valid && aw_ack; wx = w_valid && w_ack;
      tick(); cyc++;
      if (ax) awdn = 1;
      if (wx) wdn = 1;
    end
    aw_valid = 0; w_valid = 0;
    if (!(awdn && wdn)) chk("aw_w_accept_timeout", 0, 1);
    pulse = wr_pulse;
    chk("b_valid_in_commit", 64'(b_valid), 0);
    tick();
    chk("b_valid_latency", 64'(b_valid), 1);
    chk("wr_pulse_one_cycle", 64'(wr_pulse), 0);
    resp = b_resp; r0 = b_resp;
    for (int i = 0; i < bstall; i++) begin
      tick();
      chk("b_stall_valid", 64'(b_valid), 1);
      chk("b_stall_resp", 64'(b_resp), 64'(r0));
      chk("b_stall_aw_ack", 64'(aw_ack), 0);
      chk("b_stall_w_ack", 64'(w_ack), 0);
    end
    b_ack = 1; tick(); b_ack = 0;
    chk("b_valid_after_ack", 64'(b_valid), 0);
  endtask

  task automatic do_read(input logic [31:0] a, input int ard, rstall,
                         output logic [31:0] d, output logic [1:0] resp);
    bit dn = 0, x;
    int cyc = 0;
    logic [33:0] r0;
    while (!dn && cyc < 50) begin
      ar_valid = cyc >= ard; ar_data = {a, 3'($urandom)};
      x = ar_valid && ar_ack;
      tick(); cyc++;
      if (x) dn = 1;
    end
    ar_valid = 0;
    if (!dn) chk("ar_accept_timeout", 0, 1);
    chk("r_valid_latency", 64'(r_valid), 1);
    r0 = r_resp; {d, resp} = r_resp;
    for (int i = 0; i < rstall; i++) begin
      tick();
      chk("r_stall_valid", 64'(r_valid), 1);
      chk("r_stall_data", 64'(r_resp), 64'(r0));
      chk("r_stall_ar_ack", 64'(ar_ack), 0);
    end
    r_ack = 1; tick(); r_ack = 0;
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    int          dly;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    logic [7:0]  exp_pulse;
  } vec_t;

  initial begin
    vec_t tbl[$];
    logic [1:0] resp, eresp;
    logic [NR-1:0] pulse, epulse;
    logic [31:0] d, ed, a;

    tbl.push_back('{1, 32'h08, 32'hDEADBEEF, 4'hF, 2, 32'h0, 2'b00, 8'h04});
    tbl.push_back('{0, 32'h08, 32'h0, 4'h0, 0, 32'hDEADBEEF, 2'b00, 8'h00});
    tbl.push_back('{1, 32'h08, 32'h11223344, 4'h5, 0, 32'h0, 2'b00, 8'h04});
    tbl.push_back('{0, 32'h0A, 32'h0, 4'h0, 1, 32'hDE22BE44, 2'b00, 8'h00});
    tbl.push_back('{1, 32'h20, 32'h01234567, 4'hF, 0, 32'h0, 2'b10, 8'h00});
    tbl.push_back('{0, 32'h40, 32'h0, 4'h0, 0, 32'h0, 2'b10, 8'h00});
    tbl.push_back('{0, 32'h20, 32'h0, 4'h0, 0, 32'h0, 2'b10, 8'h00});
    tbl.push_back('{1, 32'h1C, 32'h89ABCDEF, 4'hF, 1, 32'h0, 2'b00, 8'h80});
    tbl.push_back('{0, 32'h1C, 32'h0, 4'h0, 0, 32'h89ABCDEF, 2'b00, 8'h00});
    tbl.push_back('{1, 32'h0C, 32'h12345678, 4'h0, 0, 32'h0, 2'b00, 8'h08});
    tbl.push_back('{0, 32'h0C, 32'h0, 4'h0, 0, 32'h0, 2'b00, 8'h00});
    tbl.push_back('{1, 32'h00, 32'hCAFEF00D, 4'hF, 0, 32'h0,
                    ID_EN ? 2'b10 : 2'b00, ID_EN ? 8'h00 : 8'h01});
    tbl.push_back('{0, 32'h00, 32'h0, 4'h0, 0, ID_EN ? ID_VAL : 32'hCAFEF00D, 2'b00, 8'h00});
    tbl.push_back('{1, 32'h80000008, 32'hFFFFFFFF, 4'hF, 0, 32'h0, 2'b10, 8'h00});
    tbl.push_back('{0, 32'h08, 32'h0, 4'h0, 0, 32'hDE22BE44, 2'b00, 8'h00});

    for (int k = 0; k < NR; k++) model[k] = '0;

    // Reset held for 3 cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_aw_ack", 64'(aw_ack), 0);
      chk("rst_w_ack", 64'(w_ack), 0);
      chk("rst_ar_ack", 64'(ar_ack), 0);
      chk("rst_b_valid", 64'(b_valid), 0);
      chk("rst_r_valid", 64'(r_valid), 0);
    end
    chk("rst_b_resp", 64'(b_resp), 0);
    chk("rst_r_resp", 64'(r_resp), 0);
    chk("rst_wr_pulse", 64'(wr_pulse), 0);
    chk_regs("rst");
    rst_i = 0; #1;
    chk("post_rst_aw_ack", 64'(aw_ack), 1);
    chk("post_rst_w_ack", 64'(w_ack), 1);
    chk("post_rst_ar_ack", 64'(ar_ack), 1);

    foreach (tbl[i]) begin
      if (tbl[i].wr) begin
        do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, tbl[i].dly, 0, resp, pulse);
        m_write(tbl[i].addr, tbl[i].data, tbl[i].strb, eresp, epulse);
        chk($sformatf("vec%0d b_resp", i), 64'(resp), 64'(tbl[i].exp_resp));
        chk($sformatf("vec%0d wr_pulse", i), 64'(pulse), 64'(tbl[i].exp_pulse));
        chk_regs($sformatf("vec%0d", i));
      end else begin
        do_read(tbl[i].addr, tbl[i].dly, 0, d, resp);
        chk($sformatf("vec%0d r_data", i), 64'(d), 64'(tbl[i].exp_data));
        chk($sformatf("vec%0d r_resp", i), 64'(resp), 64'(tbl[i].exp_resp));
      end
    end

    // Response backpressure on both channels.
    do_write(32'h10, 32'hA5A55A5A, 4'hF, 1, 0, 5, resp, pulse);
    m_write(32'h10, 32'hA5A55A5A, 4'hF, eresp, epulse);
    chk("bp b_resp", 64'(resp), 64'(eresp));
    do_read(32'h10, 0, 4, d, resp);
    chk("bp r_data", 64'(d), 64'hA5A55A5A);

    // Reset mid-transaction: captured AW and pending R must vanish.
    aw_valid = 1; aw_data = {32'h18, 3'b0}; ar_valid = 1; ar_data = {32'h10, 3'b0};
    tick();
    aw_valid = 0; ar_valid = 0;
    chk("mid r_valid_before_rst", 64'(r_valid), 1);
    rst_i = 1; tick(); rst_i = 0; #1;
    for (int k = 0; k < NR; k++) model[k] = '0;
    chk("mid r_valid", 64'(r_valid), 0);
    chk("mid aw_ack", 64'(aw_ack), 1);
    chk_regs("mid_rst");
    w_valid = 1; w_data = {32'h00C0FFEE, 4'hF};
    tick();
    w_valid = 0;
    for (int i = 0; i < 4; i++) begin
      chk("mid no_b", 64'(b_valid), 0);
      chk("mid no_pulse", 64'(wr_pulse), 0);
      tick();
    end
    aw_valid = 1; aw_data = {32'h14, 3'b0};
    tick();
    aw_valid = 0;
    chk("mid pulse", 64'(wr_pulse), 64'h20);
    tick();
    chk("mid b_valid", 64'(b_valid), 1);
    chk("mid b_resp", 64'(b_resp), 0);
    b_ack = 1; tick(); b_ack = 0;
    m_write(32'h14, 32'h00C0FFEE, 4'hF, eresp, epulse);
    chk_regs("mid_wr");

    // AR accepted in the commit cycle of a write to the same register.
    ed = model[1];
    aw_valid = 1; aw_data = {32'h4, 3'b0}; w_valid = 1; w_data = {32'h5, 4'hF};
    tick();
    aw_valid = 0; w_valid = 0;
    ar_valid = 1; ar_data = {32'h4, 3'b0};
    chk("col ar_ack", 64'(ar_ack), 1);
    chk("col pulse", 64'(wr_pulse), 64'h02);
    tick();
    ar_valid = 0;
    chk("col r_valid", 64'(r_valid), 1);
    chk("col r_data", 64'(r_resp), {30'd0, ed, 2'b00});
    chk("col b_valid", 64'(b_valid), 1);
    b_ack = 1; r_ack = 1; tick(); b_ack = 0; r_ack = 0;
    m_write(32'h4, 32'h5, 4'hF, eresp, epulse);
    do_read(32'h4, 0, 0, d, resp);
    chk("col readback", 64'(d), 64'h5);

    // Random traffic against the model.
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 7) == 0) a = 32'h20 + ($urandom & 32'hFFFF_FFDF);
      else a = 32'($urandom_range(0, NR-1) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        do_write(a, d, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2),
                 $urandom_range(0, 2), resp, pulse);
        m_write(a, d, w_data[3:0], eresp, epulse);
        chk($sformatf("rnd%0d b_resp a=%0h", n, a), 64'(resp), 64'(eresp));
        chk($sformatf("rnd%0d wr_pulse", n), 64'(pulse), 64'(epulse));
        chk_regs($sformatf("rnd%0d", n));
      end else begin
        m_read(a, ed, eresp);
        do_read(a, $urandom_range(0, 2), $urandom_range(0, 2), d, resp);
        chk($sformatf("rnd%0d r_data a=%0h", n, a), 64'(d), 64'(ed));
        chk($sformatf("rnd%0d r_resp", n), 64'(resp), 64'(eresp));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
